// File: rtl/port_uart_tx_pkg.sv
// Shared definitions for the processor's port peripherals: transmitter
// state encoding plus status and control register bit positions.
package procesor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Status byte bit positions; bits [7:6] read as 0.
    localparam int ST_HOLD = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_DONE = 2;
    localparam int ST_OVR  = 3;
    localparam int ST_EN   = 4;
    localparam int ST_IE   = 5;

    // Control byte bit positions; all other bits are ignored.
    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

endpackage

// File: rtl/port_uart_tx_if.sv
// Port bus between the core (master) and the UART transmitter (slave):
// accumulator data, write strobes, flag clear, serial line and status.
interface port_uart_tx_if;

    logic [7:0] dane;
    logic       wr_dane;
    logic       wr_ctrl;
    logic       clear_flags;
    logic       tx;
    logic [7:0] status;
    logic       tx_int;

    modport master (
        output dane, wr_dane, wr_ctrl, clear_flags,
        input  tx, status, tx_int
    );

    modport slave (
        input  dane, wr_dane, wr_ctrl, clear_flags,
        output tx, status, tx_int
    );

endinterface

// File: rtl/port_uart_tx_baud.sv
// Bit-period divider: counts CLK_DIV-1 down to 0, ticks while at 0 and
// reloads. i_load restarts a period; i_hold parks the counter at 0.
module dzielnik_baud #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_hold,
    output logic o_tick
);

    localparam int            CW    = $clog2(CLK_DIV);
    localparam logic [CW-1:0] C_TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;

    // Down-counter with load priority over hold, auto-reload on expiry.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= C_TOP;
        end else if (i_hold) begin
            r_count <= '0;
        end else if (r_count == '0) begin
            r_count <= C_TOP;
        end else begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_tick = (r_count == '0);

endmodule

// File: rtl/port_uart_tx.sv
// 8N1 serial transmitter on the processor port bus: holding register,
// LSB-first shifter, sticky DONE/OVR flags and a one-cycle interrupt.
module port_uart_tx
    import procesor_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int D_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    port_uart_tx_if.slave  bus
);

    localparam int            BW     = $clog2(D_WIDTH);
    localparam logic [BW-1:0] C_LAST = BW'(D_WIDTH - 1);

    tx_state_t          r_state;
    tx_state_t          w_next;
    logic [D_WIDTH-1:0] r_hold;
    logic [D_WIDTH-1:0] r_shift;
    logic [BW-1:0]      r_bit_idx;
    logic               r_hold_full;
    logic               r_done;
    logic               r_ovr;
    logic               r_en;
    logic               r_ie;
    logic               r_tx;
    logic               r_tx_int;
    logic               w_tick;
    logic               w_load;
    logic               w_shift;
    logic               w_frame_end;
    logic [7:0]         w_status;

    dzielnik_baud #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_hold (w_next == IDLE),
        .o_tick (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state and per-cycle strobes: load, shift, end of stop bit.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_en && r_hold_full) begin
                    w_load = 1'b1;
                    w_next = START;
                end
            end
            START: begin
                if (w_tick) w_next = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == C_LAST) w_next = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_frame_end = 1'b1;
                    // Chain straight into the next start bit when a byte waits.
                    if (r_en && r_hold_full) begin
                        w_load = 1'b1;
                        w_next = START;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Holding register, shifter, control and sticky flags; sets beat clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_en        <= 1'b0;
            r_ie        <= 1'b0;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            if (bus.wr_ctrl) begin
                r_en <= bus.dane[CTRL_EN];
                r_ie <= bus.dane[CTRL_IE];
            end
            // A write in the transfer cycle refills the slot being vacated.
            if (bus.wr_dane && (!r_hold_full || w_load)) begin
                r_hold      <= bus.dane;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load) begin
                r_shift   <= r_hold;
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + BW'(1);
            end
            if (bus.clear_flags) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_frame_end) r_done <= 1'b1;
            if (bus.wr_dane && r_hold_full && !w_load) r_ovr <= 1'b1;
        end
    end

    // Registered line driver and interrupt pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx     <= 1'b1;
            r_tx_int <= 1'b0;
        end else begin
            case (r_state)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
            r_tx_int <= w_frame_end && r_ie;
        end
    end

    // Status byte assembled for the port read mux.
    always_comb begin
        w_status          = '0;
        w_status[ST_HOLD] = r_hold_full;
        w_status[ST_BUSY] = (r_state != IDLE);
        w_status[ST_DONE] = r_done;
        w_status[ST_OVR]  = r_ovr;
        w_status[ST_EN]   = r_en;
        w_status[ST_IE]   = r_ie;
    end

    assign bus.tx     = r_tx;
    assign bus.tx_int = r_tx_int;
    assign bus.status = w_status;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx. Stimulus is a schedule of bus writes keyed to
// clock-edge numbers; the expected serial line is derived from a list of
// frames (start edge, byte, interrupt enabled) using 8N1 frame arithmetic.
module tb_port_uart_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    typedef struct {
        int         t;     // edge at which the strobe is sampled
        int         kind;  // 0 data write, 1 control write, 2 clear flags
        logic [7:0] d;
    } ev_t;

    typedef struct {
        int         s;     // edge after which the start bit appears
        logic [7:0] d;
        bit         ie;
    } frm_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    ev_t  sched_q[$];
    frm_t frm_q[$];

    port_uart_tx_if bus ();

    port_uart_tx #(.CLK_DIV(DIV), .D_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void add_ev(int t, int kind, logic [7:0] d);
        ev_t e;
        e.t = t; e.kind = kind; e.d = d;
        sched_q.push_back(e);
    endfunction

    function automatic void add_frame(int s, logic [7:0] d, bit ie);
        frm_t f;
        f.s = s; f.d = d; f.ie = ie;
        frm_q.push_back(f);
    endfunction

    // Expected line level after edge e: start bit, 8 data bits LSB first, stop.
    function automatic logic exp_line(int e);
        foreach (frm_q[i]) begin
            int o;
            int b;
            o = e - frm_q[i].s;
            if (o >= 0 && o < FRAME) begin
                b = o / DIV;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return frm_q[i].d[b-1];
            end
        end
        return 1'b1;
    endfunction

    // Interrupt is high during the last cycle of an enabled frame's stop bit.
    function automatic logic exp_int(int e);
        foreach (frm_q[i]) begin
            if (frm_q[i].ie && e == frm_q[i].s + FRAME - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive the strobes due at the coming rising edge (called at negedge).
    task automatic drive_due();
        bus.dane        = 8'h00;
        bus.wr_dane     = 1'b0;
        bus.wr_ctrl     = 1'b0;
        bus.clear_flags = 1'b0;
        foreach (sched_q[i]) begin
            if (sched_q[i].t == cyc + 1) begin
                case (sched_q[i].kind)
                    0: begin bus.wr_dane = 1'b1; bus.dane = sched_q[i].d; end
                    1: begin bus.wr_ctrl = 1'b1; bus.dane = sched_q[i].d; end
                    default: bus.clear_flags = 1'b1;
                endcase
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        frm_q.delete();
        sched_q.delete();
        drive_due();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (100) begin
            @(negedge clk);
            n_total++;
            if (bus.tx !== 1'b1 || bus.status !== 8'h00 || bus.tx_int !== 1'b0)
                $display("FAIL reset_idle @%0d: tx=%b status=%h tx_int=%b, expected 1 00 0",
                         cyc, bus.tx, bus.status, bus.tx_int);
            else n_pass++;
        end
    endtask

    task automatic test_single_frame();
        int k;
        do_reset();
        k = cyc + 4;
        add_ev(k - 1, 1, 8'h03);
        add_ev(k, 0, 8'hA5);
        add_frame(k + 2, 8'hA5, 1'b1);
        while (cyc < k + 2 + FRAME + 4) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== exp_line(cyc) || bus.tx_int !== exp_int(cyc))
                $display("FAIL single_line @%0d: tx=%b tx_int=%b, expected %b %b",
                         cyc, bus.tx, bus.tx_int, exp_line(cyc), exp_int(cyc));
            else n_pass++;
        end
        n_total++;
        if (bus.status !== 8'h34)
            $display("FAIL single_status: got %h, expected 34", bus.status);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k, s1, pulses;
        do_reset();
        k  = cyc + 4;
        s1 = k + 2;
        pulses = 0;
        add_ev(k - 1, 1, 8'h03);
        add_ev(k, 0, 8'h55);
        add_ev(s1 + $urandom_range(4, 34), 0, 8'h0F);
        add_frame(s1, 8'h55, 1'b1);
        add_frame(s1 + FRAME, 8'h0F, 1'b1);
        while (cyc < s1 + 2 * FRAME + 4) begin
            @(negedge clk);
            drive_due();
            if (bus.tx_int === 1'b1) pulses++;
            n_total++;
            if (bus.tx !== exp_line(cyc) || bus.tx_int !== exp_int(cyc))
                $display("FAIL b2b_line @%0d: tx=%b tx_int=%b, expected %b %b",
                         cyc, bus.tx, bus.tx_int, exp_line(cyc), exp_int(cyc));
            else n_pass++;
        end
        n_total++;
        if (pulses != 2) $display("FAIL b2b_pulses: got %0d, expected 2", pulses);
        else n_pass++;
        n_total++;
        if (bus.status !== 8'h34)
            $display("FAIL b2b_status: got %h, expected 34", bus.status);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int k;
        do_reset();
        k = cyc + 4;
        add_ev(k - 1, 1, 8'h01);
        add_ev(k, 0, 8'h11);
        add_ev(k + 1, 0, 8'h22);
        add_ev(k + 2, 0, 8'h33);
        add_ev(k + 2, 2, 8'h00);  // clear in the same cycle as the overrun set
        add_frame(k + 2, 8'h11, 1'b0);
        add_frame(k + 2 + FRAME, 8'h22, 1'b0);
        while (cyc < k + 2 + 2 * FRAME + 4) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== exp_line(cyc) || bus.tx_int !== 1'b0)
                $display("FAIL ovr_line @%0d: tx=%b tx_int=%b, expected %b 0",
                         cyc, bus.tx, bus.tx_int, exp_line(cyc));
            else n_pass++;
            if (cyc == k + 2) begin
                n_total++;
                if (bus.status !== 8'h1B)
                    $display("FAIL ovr_mid_status: got %h, expected 1b", bus.status);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.status !== 8'h1C)
            $display("FAIL ovr_end_status: got %h, expected 1c", bus.status);
        else n_pass++;
    endtask

    task automatic test_disable();
        int k, s, s2;
        do_reset();
        k = cyc + 4;
        s = k + 2;
        add_ev(k - 1, 1, 8'h01);
        add_ev(k, 0, 8'hC3);
        add_ev(k + 14, 0, 8'h77);
        add_ev(k + 16, 1, 8'h00);
        add_frame(s, 8'hC3, 1'b0);
        while (cyc < s + FRAME + 6) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== exp_line(cyc))
                $display("FAIL dis_line @%0d: tx=%b, expected %b", cyc, bus.tx, exp_line(cyc));
            else n_pass++;
        end
        n_total++;
        if (bus.status !== 8'h05)
            $display("FAIL dis_held_status: got %h, expected 05", bus.status);
        else n_pass++;
        s2 = cyc + 5;
        add_ev(cyc + 3, 1, 8'h01);
        add_frame(s2, 8'h77, 1'b0);
        while (cyc < s2 + FRAME + 4) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== exp_line(cyc))
                $display("FAIL dis_resume_line @%0d: tx=%b, expected %b", cyc, bus.tx, exp_line(cyc));
            else n_pass++;
        end
        n_total++;
        if (bus.status !== 8'h14)
            $display("FAIL dis_end_status: got %h, expected 14", bus.status);
        else n_pass++;
    endtask

    task automatic test_clear_race();
        int k, s;
        do_reset();
        k = cyc + 4;
        s = k + 2;
        add_ev(k - 1, 1, 8'h03);
        add_ev(k, 0, 8'($urandom));
        add_ev(s + FRAME - 1, 2, 8'h00);
        add_ev(s + FRAME + 1, 2, 8'h00);
        while (cyc < s + FRAME + 4) begin
            @(negedge clk);
            drive_due();
            if (cyc == s + FRAME - 2 || cyc == s + FRAME - 1 || cyc == s + FRAME + 1) begin
                n_total++;
                if (bus.status[2] !== (cyc == s + FRAME - 1))
                    $display("FAIL clear_race_done @%0d: got %b, expected %b",
                             cyc, bus.status[2], (cyc == s + FRAME - 1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        int k, s;
        do_reset();
        k = cyc + 4;
        s = k + 2;
        add_ev(k - 1, 1, 8'h01);
        add_ev(k, 0, 8'h00);
        add_frame(s, 8'h00, 1'b0);
        while (cyc < s + 12) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== exp_line(cyc))
                $display("FAIL rstmid_line @%0d: tx=%b, expected %b", cyc, bus.tx, exp_line(cyc));
            else n_pass++;
        end
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (bus.tx !== 1'b1 || bus.status !== 8'h00 || bus.tx_int !== 1'b0)
            $display("FAIL rstmid_async: tx=%b status=%h tx_int=%b, expected 1 00 0",
                     bus.tx, bus.status, bus.tx_int);
        else n_pass++;
        frm_q.delete();
        sched_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== 1'b1 || bus.status !== 8'h00)
                $display("FAIL rstmid_after @%0d: tx=%b status=%h, expected 1 00",
                         cyc, bus.tx, bus.status);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int k, s, e, ns;
        logic [7:0] b;
        do_reset();
        k = cyc + 3;
        b = 8'($urandom) | 8'h03;  // doubles as control word: EN and IE set
        add_ev(k, 1, b);
        add_ev(k, 0, b);
        add_frame(k + 2, b, 1'b1);
        s = k + 2;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                e  = s + $urandom_range(4, 36);
                ns = s + FRAME;
            end else begin
                e  = s + FRAME + $urandom_range(0, 6);
                ns = e + 2;
            end
            add_ev(e, 0, b);
            add_frame(ns, b, 1'b1);
            s = ns;
        end
        while (cyc < s + FRAME + 4) begin
            @(negedge clk);
            drive_due();
            n_total++;
            if (bus.tx !== exp_line(cyc) || bus.tx_int !== exp_int(cyc))
                $display("FAIL rand_line @%0d: tx=%b tx_int=%b, expected %b %b",
                         cyc, bus.tx, bus.tx_int, exp_line(cyc), exp_int(cyc));
            else n_pass++;
        end
        n_total++;
        if (bus.status !== 8'h34)
            $display("FAIL rand_status: got %h, expected 34", bus.status);
        else n_pass++;
    endtask

    initial begin
        bus.dane        = 8'h00;
        bus.wr_dane     = 1'b0;
        bus.wr_ctrl     = 1'b0;
        bus.clear_flags = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_disable();
        test_clear_race();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Serial transmit peripheral: the responder side of the processor's port write path.
- The core writes a data byte and a control byte through the accumulator bus (dane). The block buffers the byte, serialises it as 8N1, LSB first, on a single output line, and reports status back through the port read mux.
- A one-cycle transmit-complete request goes to the interrupt controller, next to the external and timer sources.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit; legal range 2..65535.
- D_WIDTH, 8: data width; fixed at 8 for the processor.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dane  in  8  data from accumulator.
- wr_dane  in  1  write dane into the holding register.
- wr_ctrl  in  1  write dane into the control register.
- clear_flags  in  1  clear the sticky status flags (done, overrun).
- tx  out  1  serial line; idle high.
- status  out  8  status byte to the port read mux.
- tx_int  out  1  one-cycle transmit-complete interrupt request.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, tx_int=0, status=0x00.
  - ctrl=0x00, holding register empty, shifter idle, divider=0, bit index=0, state IDLE.
- Control register:
  - bit0 EN: transmitter enable.
  - bit1 IE: interrupt enable.
  - Other bits are ignored and read as 0.
- Status bits:
  - [0] HOLD_FULL
  - [1] BUSY (state != IDLE)
  - [2] DONE (sticky)
  - [3] OVR (sticky)
  - [5:4] EN, IE mirrored
  - [7:6] 0
- Holding register:
  - wr_dane while empty: store the byte, HOLD_FULL=1 from the next cycle.
  - wr_dane while full and no transfer this cycle: byte dropped, OVR=1.
  - wr_dane in the same cycle as the holding-to-shifter transfer: accepted, no overrun, HOLD_FULL stays 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when EN=1 and HOLD_FULL=1, load the shifter from the holding register, clear HOLD_FULL, go to START, divider=CLK_DIV-1.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: tx=shifter[0]. At each divider expiry, shift right and increment the bit index. After bit 7 expires, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On expiry, DONE=1, and tx_int=1 for one cycle if IE=1.
    - Then, if EN=1 and HOLD_FULL=1, load directly and enter START: back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Divider: counts down from CLK_DIV-1 to 0; expiry is count==0 and reloads CLK_DIV-1. The divider is held at 0 in IDLE.
- tx is a registered output.
- Latency: wr_dane at edge k (idle, EN=1) → load at edge k+1 → tx=0 after edge k+2.
- Frame length: exactly 10*CLK_DIV cycles.
- EN cleared mid-frame: the current frame completes and no further loads occur. The holding register content is kept.
- clear_flags in the same cycle as a DONE or OVR set: set wins.
- wr_ctrl and wr_dane in the same cycle: both take effect.
- Reset mid-frame: tx returns to 1 immediately and the frame is aborted.

Decomposition:
- Shared package procesor_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - status bit index constants (ST_HOLD, ST_BUSY, ST_DONE, ST_OVR, ST_EN, ST_IE);
  - control bit constants (CTRL_EN, CTRL_IE).
- One sub-module, dzielnik_baud: parameterised down-counter with a load/hold input and a one-cycle tick output.

Test Plan:
- Reset then idle 100 cycles → tx=1, status=0x00, tx_int=0 throughout.
- CLK_DIV=4, ctrl=0x03, write 0xA5 → tx=0 two edges after the write. Line samples every 4 cycles read 0,1,0,1,0,0,1,0,1,1. tx_int pulses once at cycle 40 after the start edge, status[2]=1.
- Write 0x55, then 0x0F while the first frame is in DATA → two frames back-to-back, with the second start bit immediately after the first stop bit (80 cycles total). OVR=0 and two tx_int pulses.
- Write 0x11, 0x22, 0x33 in consecutive cycles (ctrl=0x01) → 0x11 and 0x22 transmitted, 0x33 dropped. status[3]=1, and tx_int stays 0 because IE=0.
- Mid-DATA, write ctrl=0x00 with 0x77 pending → current frame finishes, 0x77 stays held (status[0]=1). Writing ctrl=0x01 then transmits 0x77.
- Drive rst=0 mid-frame for 1 cycle asynchronously → tx=1 and status=0x00 immediately. clear_flags asserted together with a DONE set → DONE reads 1.
